multicycle_controller: RTL

//  Sequential successor to the combinational opcode/funct decoder: a multi-cycle FSM that

---
 rtl/multicycle_controller.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle FETCH/DECODE/EXEC/MEM/IO/WB sequencer for the MIPS-subset core
//
// Purpose: drives the datapath write enables, the ALU function code and the UART go-flags for one
// instruction at a time. Supports multi-cycle mult/div, a MEM/IO wait timeout, an illegal-opcode
// halt and a retired-instruction counter.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   inst       in   instruction word from IMEM, sampled in DECODE
//   dmem_ready in   data memory completes the access this cycle
//   in_ready   in   UART RX byte available
//   out_ready  in   UART TX accepts a byte
//   ir_we      out  load instruction register (FETCH)
//   pc_we      out  commit next PC, one pulse at the end of each instruction
//   reg_we     out  register-file write
//   mem_re     out  data-memory read request (lw)
//   mem_we     out  data-memory write request (sw)
//   in_gof     out  UART input go flag (IN)
//   out_gof    out  UART output go flag (OUT)
//   alu_func   out  ALU operation code, funct-field encoding
//   opetype    out  00 R-type, 01 I-type, 10 J-type
//   halted     out  FSM is in HALT
//   err        out  00 none, 01 illegal opcode, 10 MEM/IO timeout
//   instret    out  instructions retired, wraps

module multicycle_controller #(
    parameter int ALU_FUNC_W  = 6,
    parameter int MD_LATENCY  = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           inst,
    input  logic                  dmem_ready,
    input  logic                  in_ready,
    input  logic                  out_ready,
    output logic                  ir_we,
    output logic                  pc_we,
    output logic                  reg_we,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic                  in_gof,
    output logic                  out_gof,
    output logic [ALU_FUNC_W-1:0] alu_func,
    output logic [1:0]            opetype,
    output logic                  halted,
    output logic [1:0]            err,
    output logic [CNT_W-1:0]      instret
);

    // One shared counter serves the mult/div EXEC latency and the MEM/IO wait; both never overlap.
    localparam int MAX_WAIT = (MD_LATENCY > MEM_TIMEOUT) ? MD_LATENCY : MEM_TIMEOUT;
    localparam int WAIT_W   = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] MD_LAST = WAIT_W'(MD_LATENCY - 1);
    localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_IN   = 6'b011010;
    localparam logic [5:0] OP_OUT  = 6'b011011;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_IO     = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [5:0]              r_op;
    logic [5:0]              r_funct;
    logic [WAIT_W-1:0]       r_cnt;
    logic [1:0]              r_err;
    logic [CNT_W-1:0]        r_instret;

    logic [5:0]              w_op;
    logic [5:0]              w_funct;
    logic [ALU_FUNC_W-1:0]   w_alu_func;
    logic [1:0]              w_opetype;
    logic                    w_illegal;
    logic                    w_is_lw;
    logic                    w_is_sw;
    logic                    w_is_in;
    logic                    w_is_out;
    logic                    w_is_flow;
    logic                    w_is_md;
    logic                    w_exec_done;
    logic                    w_timeout;
    logic                    w_unused_inst;

    assign w_unused_inst = ^inst[25:6];

    // In DECODE the live instruction word is decoded so the illegal check and alu_func are valid
    // that very cycle; afterwards the captured fields keep them stable until the instruction ends.
    assign w_op    = (r_state == S_DECODE) ? inst[31:26] : r_op;
    assign w_funct = (r_state == S_DECODE) ? inst[5:0]   : r_funct;

    always_comb begin
        w_alu_func = '0;
        w_illegal  = 1'b0;
        case (w_op)
            OP_R:                    w_alu_func = ALU_FUNC_W'(w_funct);
            OP_ADDI, OP_LW, OP_SW:   w_alu_func = ALU_FUNC_W'(6'b100000);
            OP_ANDI:                 w_alu_func = ALU_FUNC_W'(6'b100100);
            OP_ORI:                  w_alu_func = ALU_FUNC_W'(6'b100101);
            OP_SLTI:                 w_alu_func = ALU_FUNC_W'(6'b101010);
            OP_BEQ, OP_BNE:          w_alu_func = ALU_FUNC_W'(6'b100010);
            OP_J, OP_IN, OP_OUT:     w_alu_func = '0;
            default:                 w_illegal  = 1'b1;
        endcase
    end

    assign w_opetype = (w_op == OP_R) ? 2'b00 : ((w_op == OP_J) ? 2'b10 : 2'b01);
    assign w_is_lw   = (w_op == OP_LW);
    assign w_is_sw   = (w_op == OP_SW);
    assign w_is_in   = (w_op == OP_IN);
    assign w_is_out  = (w_op == OP_OUT);
    assign w_is_flow = (w_op == OP_BEQ) || (w_op == OP_BNE) || (w_op == OP_J);
    assign w_is_md   = (w_op == OP_R) && ((w_funct == FN_MULT) || (w_funct == FN_DIV));

    assign w_exec_done = !w_is_md || (r_cnt == MD_LAST);
    assign w_timeout   = (r_cnt == TO_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = w_illegal ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (w_exec_done) begin
                    if (w_is_lw || w_is_sw)       w_next = S_MEM;
                    else if (w_is_in || w_is_out) w_next = S_IO;
                    else if (w_is_flow)           w_next = S_FETCH;
                    else                          w_next = S_WB;
                end
            end
            S_MEM: begin
                // Ready on the final wait cycle still completes normally.
                if (dmem_ready)     w_next = w_is_lw ? S_WB : S_FETCH;
                else if (w_timeout) w_next = S_HALT;
            end
            S_IO: begin
                if (w_is_in ? in_ready : out_ready) w_next = w_is_in ? S_WB : S_FETCH;
                else if (w_timeout)                 w_next = S_HALT;
            end
            S_WB:     w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // Output decode; everything is forced low while rst is asserted so an aborted
    // instruction cannot commit or write anything in the reset cycle.
    always_comb begin
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        reg_we   = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        in_gof   = 1'b0;
        out_gof  = 1'b0;
        alu_func = '0;
        opetype  = 2'b00;
        if (!rst) begin
            case (r_state)
                S_FETCH:  ir_we = 1'b1;
                S_EXEC:   pc_we = w_exec_done && w_is_flow;
                S_MEM: begin
                    mem_re = w_is_lw;
                    mem_we = w_is_sw;
                    pc_we  = w_is_sw && dmem_ready;
                end
                S_IO: begin
                    in_gof  = w_is_in;
                    out_gof = w_is_out;
                    pc_we   = w_is_out && out_ready;
                end
                S_WB: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                end
                default: ;
            endcase
            if ((r_state != S_FETCH) && (r_state != S_HALT)) begin
                alu_func = w_alu_func;
                opetype  = w_opetype;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_op      <= '0;
            r_funct   <= '0;
            r_cnt     <= '0;
            r_err     <= 2'b00;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op    <= inst[31:26];
                r_funct <= inst[5:0];
            end
            // Counter restarts on every state change, so it always counts cycles spent in the current state.
            if (w_next != r_state)
                r_cnt <= '0;
            else if ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_IO))
                r_cnt <= r_cnt + 1'b1;
            if ((r_state == S_DECODE) && w_illegal)
                r_err <= 2'b01;
            else if (((r_state == S_MEM) || (r_state == S_IO)) && (w_next == S_HALT))
                r_err <= 2'b10;
            if (pc_we)
                r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign halted  = (r_state == S_HALT) && !rst;
    assign err     = r_err;
    assign instret = r_instret;

endmodule
